param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/sdp_ram.sv | 53 +++++
 rtl/param_sync_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_param_sync_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and parameter-legality helpers for param_sync_fifo.
//   RAM_* / MODE_*  : accepted string values for RAM_TYPE and READ_MODE.
//   *_legal()       : constant functions evaluated at elaboration time so an
//                     illegal configuration stops the build instead of
//                     producing a silently broken FIFO.
package fifo_pkg;

    localparam string RAM_DISTRIBUTED = "distributed";
    localparam string RAM_BLOCK       = "block";
    localparam string MODE_STD        = "STD";
    localparam string MODE_FWFT       = "FWFT";

    function automatic bit ram_type_legal(input string ram_type);
        return (ram_type == RAM_DISTRIBUTED) || (ram_type == RAM_BLOCK);
    endfunction

    function automatic bit read_mode_legal(input string read_mode);
        return (read_mode == MODE_STD) || (read_mode == MODE_FWFT);
    endfunction

    function automatic bit width_legal(input int data_width, input int addr_width);
        return (data_width >= 1) && (addr_width >= 1) && (addr_width <= 30);
    endfunction

    // almost_full threshold must be reachable and non-trivial: 1..DEPTH
    function automatic bit af_thresh_legal(input int addr_width, input int af_thresh);
        return (af_thresh >= 1) && (af_thresh <= (1 << addr_width));
    endfunction

    // almost_empty threshold: 0..DEPTH-1
    function automatic bit ae_thresh_legal(input int addr_width, input int ae_thresh);
        return (ae_thresh >= 0) && (ae_thresh <= (1 << addr_width) - 1);
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port storage for param_sync_fifo.
//   clk              : single clock, rising edge
//   wr_en/wr_addr/wr_data : write port, written on the rising edge
//   rd_en/rd_addr    : read port; rd_en only matters for block style
//   rd_data          : combinational for "distributed", registered
//                      (updated on rd_en) for "block"
// Contents are never reset.
module sdp_ram
    import fifo_pkg::*;
#(
    parameter string RAM_TYPE   = RAM_DISTRIBUTED,
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (RAM_TYPE == RAM_BLOCK) begin : g_block
        (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            // read-during-write to the same address returns the old word;
            // the controller never relies on that case
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end else begin : g_distributed
        (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic rd_en_unused;

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end

        assign rd_data      = mem[rd_addr];
        assign rd_en_unused = rd_en;
    end

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with selectable storage style and
// read mode (STD registered read, or FWFT first-word fall-through).
//   clk, a_rst_n        : clock (rising edge), asynchronous active-low reset
//   wr_data, wr_en      : write side; full / almost_full / overflow status
//   rd_en               : read request (STD) or head acknowledge (FWFT)
//   rd_data, rd_data_vld: read word and its qualifier
//   empty / almost_empty / underflow : read-side status
//   fill_count          : words held, 0..DEPTH (FWFT head word included)
// All status outputs are registered; nothing combinational from wr_en/rd_en.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter string RAM_TYPE   = RAM_DISTRIBUTED,
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 4,
    parameter string READ_MODE  = MODE_STD,
    parameter int    AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int    AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  a_rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_vld,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fill_count
);

    localparam bit IS_FWFT  = (READ_MODE == MODE_FWFT);
    localparam bit IS_BLOCK = (RAM_TYPE == RAM_BLOCK);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH+1)'(AE_THRESH);

    // ---------------------------------------------------------------
    // Elaboration-time legality checks
    // ---------------------------------------------------------------
    if (!ram_type_legal(RAM_TYPE)) begin : g_bad_ram_type
        $error("param_sync_fifo: RAM_TYPE must be \"distributed\" or \"block\"");
    end
    if (!read_mode_legal(READ_MODE)) begin : g_bad_read_mode
        $error("param_sync_fifo: READ_MODE must be \"STD\" or \"FWFT\"");
    end
    if (!width_legal(DATA_WIDTH, ADDR_WIDTH)) begin : g_bad_width
        $error("param_sync_fifo: DATA_WIDTH/ADDR_WIDTH out of range");
    end
    if (!af_thresh_legal(ADDR_WIDTH, AF_THRESH)) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH must be 1..DEPTH");
    end
    if (!ae_thresh_legal(ADDR_WIDTH, AE_THRESH)) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH must be 0..DEPTH-1");
    end

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    // Pointers carry an extra wrap bit so all DEPTH slots are usable.
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   fill_count_q, fill_count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    // STD: one-cycle read-valid pulse. FWFT: prefetch (head) valid.
    logic                  rd_vld_q, rd_vld_d;
    // STD distributed: read output register. FWFT distributed: prefetch word.
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    // STD block: rd_data comes from the RAM output register, which is not
    // reset; this flag blanks it until the first read after reset.
    logic                  rd_seen_q, rd_seen_d;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  ram_has_data_d;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    sdp_ram #(
        .RAM_TYPE   (RAM_TYPE),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    // In FWFT the head word keeps its RAM slot until it is popped, so the
    // pointer difference is the fill count in both modes and full/empty of
    // the storage come straight from the pointers.
    always_comb begin
        wr_accept = wr_en && !full_q;
        // empty_q already means "no word readable" in every mode
        rd_accept = rd_en && !empty_q;

        wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_accept};
        rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_accept};

        fill_count_d   = wr_ptr_d - rd_ptr_d;
        full_d         = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                         (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
        ram_has_data_d = (wr_ptr_d != rd_ptr_d);
        almost_full_d  = (fill_count_d >= AF_LEVEL);
        almost_empty_d = (fill_count_d <= AE_LEVEL);
        overflow_d     = wr_en && full_q;
        underflow_d    = rd_en && empty_q;

        empty_d     = !ram_has_data_d;
        rd_vld_d    = 1'b0;
        rd_data_d   = rd_data_q;
        rd_seen_d   = rd_seen_q;
        ram_rd_en   = 1'b0;
        ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

        if (!IS_FWFT) begin
            // STD: fetch the head on an accepted read, present it next cycle
            rd_vld_d  = rd_accept;
            ram_rd_en = rd_accept;
            if (rd_accept) begin
                rd_seen_d = 1'b1;
                if (!IS_BLOCK) begin
                    rd_data_d = ram_rd_data;
                end
            end
        end else if (!IS_BLOCK) begin
            // FWFT distributed: reload the prefetch register every cycle
            // with the head that will exist after this edge. If that head is
            // the word being written right now, take it from wr_data.
            ram_rd_addr = rd_ptr_d[ADDR_WIDTH-1:0];
            rd_vld_d    = ram_has_data_d;
            if (ram_has_data_d) begin
                if (wr_accept && (rd_ptr_d == wr_ptr_q)) begin
                    rd_data_d = wr_data;
                end else begin
                    rd_data_d = ram_rd_data;
                end
            end
            empty_d = !rd_vld_d;
        end else begin
            // FWFT block: the RAM output register acts as the prefetch word.
            // It can only hold the next head if that word was written before
            // this edge, which gives the extra cycle of fall-through latency.
            ram_rd_en   = 1'b1;
            ram_rd_addr = rd_ptr_d[ADDR_WIDTH-1:0];
            rd_vld_d    = (rd_ptr_d != wr_ptr_q);
            empty_d     = !rd_vld_d;
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_count_q   <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_vld_q       <= 1'b0;
            rd_data_q      <= '0;
            rd_seen_q      <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_count_q   <= fill_count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            rd_vld_q       <= rd_vld_d;
            rd_data_q      <= rd_data_d;
            rd_seen_q      <= rd_seen_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    // Block styles read straight from the RAM output register; it is gated
    // so rd_data still reads zero immediately after reset.
    always_comb begin
        rd_data = rd_data_q;
        if (IS_BLOCK) begin
            if (IS_FWFT ? rd_vld_q : rd_seen_q) begin
                rd_data = ram_rd_data;
            end else begin
                rd_data = '0;
            end
        end
    end

    assign rd_data_vld  = rd_vld_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign fill_count   = fill_count_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo. Four instances cover STD/FWFT x distributed/block.
// Each instance in turn gets directed sequences and a random run; every
// cycle its outputs are compared with a queue-based model in which a word
// becomes visible in FWFT a fixed number of edges after it was written.
module tb_param_sync_fifo;

    localparam int N_DUT = 4;   // 0 STD/dist, 1 STD/block, 2 FWFT/dist, 3 FWFT/block
    localparam int DEPTH = 16;

    logic       clk;
    logic       a_rst_n;
    logic       wr_en    [N_DUT];
    logic [7:0] wr_data  [N_DUT];
    logic       rd_en    [N_DUT];
    logic [7:0] rd_data  [N_DUT];
    logic       rd_vld   [N_DUT];
    logic       full_o   [N_DUT];
    logic       afull_o  [N_DUT];
    logic       ovf_o    [N_DUT];
    logic       empty_o  [N_DUT];
    logic       aempty_o [N_DUT];
    logic       unf_o    [N_DUT];
    logic [4:0] fill_o   [N_DUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    param_sync_fifo #(.RAM_TYPE("distributed"), .DATA_WIDTH(8), .ADDR_WIDTH(4),
                      .READ_MODE("STD"), .AF_THRESH(14), .AE_THRESH(2)) u_std_dist (
        .clk(clk), .a_rst_n(a_rst_n), .wr_data(wr_data[0]), .wr_en(wr_en[0]),
        .full(full_o[0]), .almost_full(afull_o[0]), .overflow(ovf_o[0]),
        .rd_en(rd_en[0]), .rd_data(rd_data[0]), .rd_data_vld(rd_vld[0]),
        .empty(empty_o[0]), .almost_empty(aempty_o[0]), .underflow(unf_o[0]),
        .fill_count(fill_o[0]));

    param_sync_fifo #(.RAM_TYPE("block"), .DATA_WIDTH(8), .ADDR_WIDTH(4),
                      .READ_MODE("STD"), .AF_THRESH(14), .AE_THRESH(2)) u_std_block (
        .clk(clk), .a_rst_n(a_rst_n), .wr_data(wr_data[1]), .wr_en(wr_en[1]),
        .full(full_o[1]), .almost_full(afull_o[1]), .overflow(ovf_o[1]),
        .rd_en(rd_en[1]), .rd_data(rd_data[1]), .rd_data_vld(rd_vld[1]),
        .empty(empty_o[1]), .almost_empty(aempty_o[1]), .underflow(unf_o[1]),
        .fill_count(fill_o[1]));

    param_sync_fifo #(.RAM_TYPE("distributed"), .DATA_WIDTH(8), .ADDR_WIDTH(4),
                      .READ_MODE("FWFT"), .AF_THRESH(14), .AE_THRESH(2)) u_fwft_dist (
        .clk(clk), .a_rst_n(a_rst_n), .wr_data(wr_data[2]), .wr_en(wr_en[2]),
        .full(full_o[2]), .almost_full(afull_o[2]), .overflow(ovf_o[2]),
        .rd_en(rd_en[2]), .rd_data(rd_data[2]), .rd_data_vld(rd_vld[2]),
        .empty(empty_o[2]), .almost_empty(aempty_o[2]), .underflow(unf_o[2]),
        .fill_count(fill_o[2]));

    param_sync_fifo #(.RAM_TYPE("block"), .DATA_WIDTH(8), .ADDR_WIDTH(4),
                      .READ_MODE("FWFT"), .AF_THRESH(14), .AE_THRESH(2)) u_fwft_block (
        .clk(clk), .a_rst_n(a_rst_n), .wr_data(wr_data[3]), .wr_en(wr_en[3]),
        .full(full_o[3]), .almost_full(afull_o[3]), .overflow(ovf_o[3]),
        .rd_en(rd_en[3]), .rd_data(rd_data[3]), .rd_data_vld(rd_vld[3]),
        .empty(empty_o[3]), .almost_empty(aempty_o[3]), .underflow(unf_o[3]),
        .fill_count(fill_o[3]));

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] d;   // data word
        int         e;   // edge number at which it was written
    } ent_t;

    ent_t       mq[$];
    int         cur;
    string      phase;
    int         checks;
    int         failures;
    bit         exp_ovf;
    bit         exp_unf;
    bit         exp_std_vld;
    logic [7:0] exp_std_data;

    // Is the head word readable after edge n?  STD: whenever stored.
    // FWFT distributed: from its write edge on; FWFT block: one edge later.
    function automatic bit head_vis(input int n);
        if (mq.size() == 0) return 1'b0;
        if (cur < 2) return 1'b1;
        return n >= mq[0].e + ((cur % 2 == 1) ? 1 : 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL dut%0d %s/%s observed=0x%0h expected=0x%0h t=%0t",
                   cur, phase, tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        bit vis;
        n   = mq.size();
        vis = head_vis(edge_cnt);
        check("fill_count",   32'(fill_o[cur]),   32'(n));
        check("full",         32'(full_o[cur]),   32'(n == DEPTH));
        check("almost_full",  32'(afull_o[cur]),  32'(n >= 14));
        check("almost_empty", 32'(aempty_o[cur]), 32'(n <= 2));
        check("overflow",     32'(ovf_o[cur]),    32'(exp_ovf));
        check("underflow",    32'(unf_o[cur]),    32'(exp_unf));
        if (cur < 2) begin
            check("empty",       32'(empty_o[cur]), 32'(n == 0));
            check("rd_data_vld", 32'(rd_vld[cur]),  32'(exp_std_vld));
            check("rd_data",     32'(rd_data[cur]), 32'(exp_std_data));
        end else begin
            check("empty",       32'(empty_o[cur]), 32'(!vis));
            check("rd_data_vld", 32'(rd_vld[cur]),  32'(vis));
            if (vis) check("rd_data", 32'(rd_data[cur]), 32'(mq[0].d));
        end
    endtask

    // One clock cycle of stimulus on the current instance, then compare.
    task automatic step(input bit w, input logic [7:0] d, input bit r);
        bit   full_m, readable_m, wr_acc, rd_acc;
        ent_t ent;
        full_m     = (mq.size() == DEPTH);
        readable_m = head_vis(edge_cnt);
        wr_acc     = w && !full_m;
        rd_acc     = r && readable_m;
        wr_en[cur]   = w;
        wr_data[cur] = d;
        rd_en[cur]   = r;
        @(posedge clk);
        #1;
        wr_en[cur] = 1'b0;
        rd_en[cur] = 1'b0;
        exp_ovf     = w && full_m;
        exp_unf     = r && !readable_m;
        exp_std_vld = rd_acc;
        if (rd_acc) begin
            ent = mq.pop_front();
            if (cur < 2) exp_std_data = ent.d;
        end
        if (wr_acc) begin
            ent.d = d;
            ent.e = edge_cnt;
            mq.push_back(ent);
        end
        $display("dut%0d %s t=%0t wr=%0b d=%02h rd=%0b -> fill=%0d vld=%0b q=%02h",
                 cur, phase, $time, w, d, r, fill_o[cur], rd_vld[cur], rd_data[cur]);
        check_all();
    endtask

    // Assert reset between edges, check the immediate effect before the next
    // edge, then release between edges.
    task automatic do_reset();
        #2;
        a_rst_n = 1'b0;
        #1;
        mq.delete();
        exp_ovf      = 1'b0;
        exp_unf      = 1'b0;
        exp_std_vld  = 1'b0;
        exp_std_data = 8'h00;
        check_all();
        @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cur      = 0;
        phase    = "reset";
        a_rst_n  = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            wr_en[i]   = 1'b0;
            rd_en[i]   = 1'b0;
            wr_data[i] = 8'h00;
        end

        for (int k = 0; k < N_DUT; k++) begin
            cur   = k;
            phase = "reset";
            do_reset();

            // fill to full, one rejected write, drain in order, underflows
            phase = "fill";
            for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
            step(1'b1, 8'hAA, 1'b0);
            step(1'b0, 8'h00, 1'b0);
            phase = "drain";
            for (int i = 0; i < 18; i++) step(1'b0, 8'h00, 1'b1);
            step(1'b0, 8'h00, 1'b0);

            // single-word latency, with and without an idle cycle
            phase = "latency";
            step(1'b1, 8'h5A, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            step(1'b0, 8'h00, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            step(1'b1, 8'h3C, 1'b0);
            step(1'b0, 8'h00, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            step(1'b0, 8'h00, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            step(1'b0, 8'h00, 1'b0);

            // steady level under simultaneous read/write, then at full
            phase = "concur";
            for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
            step(1'b0, 8'h00, 1'b0);
            for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
            phase = "full_rw";
            for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
            step(1'b1, 8'hEE, 1'b1);
            step(1'b0, 8'h00, 1'b0);
            for (int i = 0; i < 18; i++) step(1'b0, 8'h00, 1'b1);

            // random traffic alternating between write-heavy and read-heavy
            phase = "random";
            for (int i = 0; i < 160; i++) begin
                int pw;
                int pr;
                pw = ((i / 40) % 2 == 0) ? 75 : 35;
                pr = ((i / 40) % 2 == 0) ? 35 : 75;
                step(1'($urandom_range(0, 99) < pw), 8'($urandom),
                     1'($urandom_range(0, 99) < pr));
            end

            // asynchronous reset with nine words stored
            phase = "midrst";
            while (mq.size() > 9) step(1'b0, 8'h00, 1'b1);
            while (mq.size() < 9) step(1'b1, 8'($urandom), 1'b0);
            step(1'b0, 8'h00, 1'b0);
            do_reset();
            step(1'b0, 8'h00, 1'b1);
            step(1'b1, 8'h77, 1'b0);
            step(1'b0, 8'h00, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            step(1'b0, 8'h00, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
